// File: rtl/spi_tx_fifo.sv
// Transmit FIFO between a host write port and an SPI master that pulls words on request.
// Optional sticky overflow/underflow flags are enabled by defining SPI_TX_FIFO_STATUS_EN.
module spi_tx_fifo #(
  parameter int data_width_c = 8,
  parameter int depth_g      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [data_width_c-1:0]   wr_data,
  input  logic                      flush,
  input  logic                      fifo_req_data,
  output logic [data_width_c-1:0]   fifo_din,
  output logic                      fifo_din_valid,
  output logic                      fifo_empty,
  output logic                      full,
`ifdef SPI_TX_FIFO_STATUS_EN
  output logic                      overflow,
  output logic                      underflow,
`endif
  output logic [$clog2(depth_g):0]  used
);

  localparam int AW = $clog2(depth_g);

  logic [data_width_c-1:0] r_mem [depth_g];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [AW:0]             r_used;
  logic                    r_empty;
  logic                    r_full;
  logic [data_width_c-1:0] r_dout;
  logic                    r_valid;

  logic                    w_rd_acc;
  logic                    w_wr_acc;
  logic [AW:0]             w_used_next;

  // A read is only granted against words already stored, so a write into an
  // empty FIFO is never bypassed to the same-cycle request.
  assign w_rd_acc = fifo_req_data & ~r_empty & ~flush & ~rst;
  assign w_wr_acc = wr_en & (~r_full | w_rd_acc) & ~flush & ~rst;

  always_comb begin
    w_used_next = r_used;
    if (w_wr_acc && !w_rd_acc)
      w_used_next = r_used + (AW+1)'(1);
    else if (w_rd_acc && !w_wr_acc)
      w_used_next = r_used - (AW+1)'(1);
  end

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc)
      r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
    end else if (w_rd_acc) begin
      r_dout <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used   <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_used  <= w_used_next;
      r_empty <= (w_used_next == '0);
      r_full  <= (w_used_next == (AW+1)'(depth_g));
      r_valid <= w_rd_acc;
    end
  end

`ifdef SPI_TX_FIFO_STATUS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && r_full && !w_rd_acc)
        r_overflow <= 1'b1;
      if (fifo_req_data && r_empty)
        r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign fifo_din       = r_dout;
  assign fifo_din_valid = r_valid;
  assign fifo_empty     = r_empty;
  assign full           = r_full;
  assign used           = r_used;

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Self-checking bench for spi_tx_fifo: directed vector table, corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_spi_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, wr_en, flush, fifo_req_data;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] fifo_din;
  logic          fifo_din_valid, fifo_empty, full;
  logic [$clog2(DEPTH):0] used;
`ifdef SPI_TX_FIFO_STATUS_EN
  logic          overflow, underflow;
`endif

  always #5 clk = ~clk;

  spi_tx_fifo #(.data_width_c(DW), .depth_g(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .flush(flush),
    .fifo_req_data(fifo_req_data),
    .fifo_din(fifo_din),
    .fifo_din_valid(fifo_din_valid),
    .fifo_empty(fifo_empty),
    .full(full),
`ifdef SPI_TX_FIFO_STATUS_EN
    .overflow(overflow),
    .underflow(underflow),
`endif
    .used(used)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, plus last delivered word.
  logic [DW-1:0] q[$];
  logic          m_valid;
  logic [DW-1:0] m_din;
  logic          m_ovf, m_udf;

  typedef struct {
    logic          r, f, w;
    logic [DW-1:0] d;
    logic          rq;
    logic          ev;
    logic [DW-1:0] ed;
    int            eu;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic w,
                      input logic [DW-1:0] d, input logic rq);
    bit rd, wok;
    rst = r; flush = f; wr_en = w; wr_data = d; fifo_req_data = rq;
    if (r) begin
      q.delete(); m_valid = 1'b0; m_din = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (f) begin
      q.delete(); m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      rd  = rq && (q.size() > 0);
      wok = w && ((q.size() < DEPTH) || rd);
      if (w && !wok) m_ovf = 1'b1;
      if (rq && q.size() == 0) m_udf = 1'b1;
      if (rd) begin
        m_din   = q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (wok) q.push_back(d);
    end
    @(posedge clk);
    #1;
    chk("valid", fifo_din_valid, m_valid);
    chk("din",   fifo_din, m_din);
    chk("used",  used, q.size());
    chk("empty", fifo_empty, q.size() == 0);
    chk("full",  full, q.size() == DEPTH);
`ifdef SPI_TX_FIFO_STATUS_EN
    chk("overflow",  overflow, m_ovf);
    chk("underflow", underflow, m_udf);
`endif
    $display("cyc rst=%0b fl=%0b wr=%0b d=%02h rq=%0b -> v=%0b din=%02h used=%0d",
             r, f, w, d, rq, fifo_din_valid, fifo_din, used);
  endtask

  vec_t vecs[12];

  initial begin
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_data = '0; fifo_req_data = 1'b0;

    // Directed table: basic ordering, empty request, no-bypass write, flush.
    vecs[0]  = '{1,0,0,8'h00,0, 0,8'h00,0};
    vecs[1]  = '{0,0,1,8'h11,0, 0,8'h00,1};
    vecs[2]  = '{0,0,1,8'h22,0, 0,8'h00,2};
    vecs[3]  = '{0,0,1,8'h33,0, 0,8'h00,3};
    vecs[4]  = '{0,0,0,8'h00,1, 1,8'h11,2};
    vecs[5]  = '{0,0,0,8'h00,1, 1,8'h22,1};
    vecs[6]  = '{0,0,0,8'h00,1, 1,8'h33,0};
    vecs[7]  = '{0,0,0,8'h00,1, 0,8'h33,0};
    vecs[8]  = '{0,0,1,8'h5A,1, 0,8'h33,1};
    vecs[9]  = '{0,0,0,8'h00,1, 1,8'h5A,0};
    vecs[10] = '{0,1,1,8'h77,0, 0,8'h5A,0};
    vecs[11] = '{0,0,0,8'h00,0, 0,8'h5A,0};
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].r, vecs[i].f, vecs[i].w, vecs[i].d, vecs[i].rq);
      chk("tbl_valid", fifo_din_valid, vecs[i].ev);
      chk("tbl_din",   fifo_din, vecs[i].ed);
      chk("tbl_used",  used, vecs[i].eu);
    end

    // Fill to full, drop one, then simultaneous read/write at full.
    step(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'(i), 0);
    step(0, 0, 1, 8'hAA, 0);
    chk("full_after_drop", full, 1);
    chk("used_after_drop", used, DEPTH);
    step(0, 0, 1, 8'hBB, 1);
    chk("rdwr_full_din",  fifo_din, 8'h00);
    chk("rdwr_full_used", used, DEPTH);
    for (int i = 1; i < DEPTH; i++) begin
      step(0, 0, 0, 8'h00, 1);
      chk("drain_din", fifo_din, 8'(i));
    end
    step(0, 0, 0, 8'h00, 1);
    chk("drain_last", fifo_din, 8'hBB);
    step(0, 0, 0, 8'h00, 0);
    chk("drain_empty", fifo_empty, 1);

    // Reset, then flush, colliding with a read request.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'hC0 + i), 0);
    step(1, 0, 0, 8'h00, 1);
    chk("rst_rd_valid", fifo_din_valid, 0);
    step(0, 0, 0, 8'h00, 0);
    chk("rst_rd_valid2", fifo_din_valid, 0);
    chk("rst_rd_empty", fifo_empty, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'hD0 + i), 0);
    step(0, 1, 0, 8'h00, 1);
    chk("flush_rd_valid", fifo_din_valid, 0);
    chk("flush_used", used, 0);
    step(0, 0, 0, 8'h00, 0);
    chk("flush_empty", fifo_empty, 1);

    // Randomized traffic; write bias varies so the FIFO runs both near full and near empty.
    for (int i = 0; i < 1500; i++) begin
      int wbias;
      wbias = ((i / 150) % 2 == 0) ? 70 : 35;
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 99) == 0,
           $urandom_range(0, 99) < wbias,
           8'($urandom),
           $urandom_range(0, 99) < 50);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_tx_fifo.md
SPI_TX_FIFO -- requirements
Module: spi_tx_fifo

Interface
REQ-001 SHALL have parameter data_width_c, default 8, width of one SPI data word.
REQ-002 SHALL have parameter depth_g, default 16, number of stored words; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  host write strobe, one word per cycle.
REQ-006 SHALL have port wr_data  input  data_width_c  host write word.
REQ-007 SHALL have port flush  input  1  synchronous clear of stored contents.
REQ-008 SHALL have port fifo_req_data  input  1  SPI master requests next word.
REQ-009 SHALL have port fifo_din  output  data_width_c  word delivered to the SPI master.
REQ-010 SHALL have port fifo_din_valid  output  1  fifo_din holds a delivered word this cycle.
REQ-011 SHALL have port fifo_empty  output  1  no word stored.
REQ-012 SHALL have port full  output  1  depth_g words stored.
REQ-013 SHALL have port used  output  $clog2(depth_g)+1  stored word count.

Function
REQ-014 Write accepted when wr_en=1 and (full=0 or read accepted same cycle); accepted word stored at write pointer.
REQ-015 wr_en=1 with full=1 and no read accepted: word dropped; contents, pointers and used unchanged.
REQ-016 Read accepted when fifo_req_data=1 and fifo_empty=0, both sampled in the same cycle.
REQ-017 Accepted read: next cycle fifo_din = oldest word, fifo_din_valid=1 for exactly one cycle; latency fixed at 1 cycle.
REQ-018 fifo_req_data=1 with fifo_empty=1: ignored; next cycle fifo_din_valid=0; no pending request retained.
REQ-019 fifo_din holds its last delivered value while fifo_din_valid=0.
REQ-020 Simultaneous accepted read and write: used unchanged; both pointers advance.
REQ-021 Write into empty FIFO with fifo_req_data=1 same cycle: read not accepted (no bypass); word readable from next cycle.
REQ-022 Back-to-back fifo_req_data on consecutive cycles: one word per cycle; fifo_din_valid continuous.
REQ-023 Read and write pointers wrap modulo depth_g; used counts 0..depth_g inclusive.
REQ-024 fifo_empty = (used==0), full = (used==depth_g), both registered; update on the cycle after the access that changes used.
REQ-025 flush=1: next cycle used=0, pointers=0, fifo_empty=1, full=0; same-cycle wr_en and fifo_req_data ignored; fifo_din_valid=0 next cycle.

Reset
REQ-026 rst=1 at rising edge: pointers=0, used=0, fifo_empty=1, full=0, fifo_din_valid=0, fifo_din=0.
REQ-027 Reset mid-operation discards all stored words and any in-flight read; no fifo_din_valid pulse after the reset edge.
REQ-028 rst has priority over flush, wr_en and fifo_req_data.
REQ-029 Storage array contents need not be reset.

Configuration
REQ-030 Macro SPI_TX_FIFO_STATUS_EN defined: add outputs overflow (1 bit) and underflow (1 bit), sticky, set on a REQ-015 drop and on a REQ-018 ignored request respectively, cleared only by rst or flush, reset value 0.
REQ-031 Macro SPI_TX_FIFO_STATUS_EN undefined: overflow and underflow ports and logic absent; all other behaviour identical.

Verification
REQ-032 Reset, then write 0x11,0x22,0x33; pulse fifo_req_data three cycles -> fifo_din 0x11,0x22,0x33 on consecutive cycles with fifo_din_valid=1, then fifo_empty=1, used=0.
REQ-033 Write 16 words 0x00..0x0F, 17th write 0xAA -> full=1, used=16, 0xAA dropped (overflow=1 with SPI_TX_FIFO_STATUS_EN); drain -> 0x00..0x0F in order.
REQ-034 Full FIFO, wr_en with 0xBB and fifo_req_data same cycle -> used stays 16, read returns 0x00, 0xBB returned last after draining.
REQ-035 Empty FIFO, fifo_req_data=1 -> fifo_din_valid=0 next cycle, fifo_din unchanged (underflow=1 with macro); write 0x5A with same-cycle request -> no delivery that cycle, 0x5A delivered on following request.
REQ-036 Write 40 words with interleaved reads, never exceeding 16 stored -> pointer wrap, all words delivered in order, no loss.
REQ-037 Store 5 words, assert rst in same cycle as fifo_req_data -> no fifo_din_valid afterwards, fifo_empty=1, used=0; repeat with flush -> same result.
